// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo
//   Store-and-forward packet FIFO for one switch port. Frames are written
//   speculatively and only become visible to the reader on a good commit.
//   Bad, runt, jumbo or overflowing frames are rolled back. The reader can
//   stream the head frame or discard it without reading it.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   wr_start             : first cycle of a new frame (rolls back any open frame)
//   wr_valid/data/bytes  : frame beats, byte 0 in the MSBs
//   wr_meta              : header metadata, captured on wr_commit
//   wr_commit / wr_drop  : frame ended good / bad
//   stat_*               : one-cycle outcome pulses, the cycle after commit
//   rd_meta_valid/meta/len : head frame descriptor (IDLE only)
//   rd_fwd_en / rd_pop   : stream the head frame / discard it
//   rd_valid/data/bytes/last : output beats
//   free_lines           : DEPTH minus committed and in-progress lines
module rx_packet_fifo #(
    parameter int DATA_WIDTH      = 128,
    parameter int DEPTH           = 8192,
    parameter int META_DEPTH      = 2048,
    parameter int META_WIDTH      = 112,
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int LEN_BITS        = $clog2(MAX_FRAME_BYTES + 2)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_start,
    input  logic                               wr_valid,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [$clog2(DATA_WIDTH/8+1)-1:0]  wr_bytes,
    input  logic [META_WIDTH-1:0]              wr_meta,
    input  logic                               wr_commit,
    input  logic                               wr_drop,
    output logic                               stat_queued,
    output logic                               stat_drop_fifo,
    output logic                               stat_drop_runt,
    output logic                               stat_drop_jumbo,
    output logic                               rd_meta_valid,
    output logic [META_WIDTH-1:0]              rd_meta,
    output logic [LEN_BITS-1:0]                rd_len,
    input  logic                               rd_fwd_en,
    input  logic                               rd_pop,
    output logic                               rd_valid,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic [$clog2(DATA_WIDTH/8+1)-1:0]  rd_bytes,
    output logic                               rd_last,
    output logic [$clog2(DEPTH):0]             free_lines
);

    localparam int BPL = DATA_WIDTH / 8;
    localparam int BW  = $clog2(BPL + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int MAW = $clog2(META_DEPTH);
    localparam int MPW = MAW + 1;

    typedef struct packed {
        logic [LEN_BITS-1:0]   len;
        logic [META_WIDTH-1:0] meta;
    } meta_entry_t;

    typedef enum logic {IDLE, STREAM} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    meta_entry_t           meta_mem [META_DEPTH];

    // Write-side state
    logic [PW-1:0]       wr_spec_q, wr_cptr_q;
    logic [LEN_BITS-1:0] len_q;
    logic                ovf_q, jumbo_q;
    logic [MPW-1:0]      mwr_q;

    // Read-side state
    logic [PW-1:0]       rd_ptr_q;
    logic [MPW-1:0]      mrd_q;
    rd_state_t           state_q;
    logic [LEN_BITS-1:0] rem_q;
    logic [BW-1:0]       last_bytes_q;
    logic [DATA_WIDTH-1:0] ram_q;

    // Write-side next state
    logic [PW-1:0]       spec_base, spec_d;
    logic [LEN_BITS-1:0] len_base, len_d;
    logic                ovf_d, jumbo_d, ram_we, meta_push, meta_full;
    logic                queued_d, drop_fifo_d, drop_runt_d, drop_jumbo_d;
    int                  beat_len;

    assign meta_full = (mwr_q - mrd_q) == MPW'(META_DEPTH);

    // NOTE: every combinational output gets a default first, so no path
    // through the if/else tree can leave one unassigned and infer a latch.
    always_comb begin
        // wr_start takes effect in its own cycle so it may carry the first beat.
        spec_base    = wr_start ? wr_cptr_q : wr_spec_q;
        len_base     = wr_start ? '0 : len_q;
        ovf_d        = wr_start ? 1'b0 : ovf_q;
        jumbo_d      = wr_start ? 1'b0 : jumbo_q;
        spec_d       = spec_base;
        len_d        = len_base;
        ram_we       = 1'b0;
        meta_push    = 1'b0;
        queued_d     = 1'b0;
        drop_fifo_d  = 1'b0;
        drop_runt_d  = 1'b0;
        drop_jumbo_d = 1'b0;
        beat_len     = int'(len_base) + int'(wr_bytes);

        if (wr_valid && !ovf_d && !jumbo_d) begin
            if ((spec_base - rd_ptr_q) == PW'(DEPTH)) begin
                ovf_d = 1'b1;
            end else if (beat_len > MAX_FRAME_BYTES) begin
                jumbo_d = 1'b1;
            end else begin
                ram_we = 1'b1;
                spec_d = spec_base + PW'(1);
                len_d  = LEN_BITS'(beat_len);
            end
        end

        if (wr_drop) begin
            spec_d = wr_cptr_q;
        end else if (wr_commit) begin
            if (ovf_d || meta_full)                  drop_fifo_d  = 1'b1;
            else if (jumbo_d)                        drop_jumbo_d = 1'b1;
            else if (int'(len_d) < MIN_FRAME_BYTES)  drop_runt_d  = 1'b1;
            else begin
                meta_push = 1'b1;
                queued_d  = 1'b1;
            end
            if (!meta_push) spec_d = wr_cptr_q;
        end
    end

    // Read side: head descriptor and FSM next state
    meta_entry_t         head;
    logic                meta_nonempty;
    int                  head_lines;
    rd_state_t           state_d;
    logic [LEN_BITS-1:0] rem_d;
    logic [BW-1:0]       last_bytes_d;
    logic [PW-1:0]       rd_ptr_d;
    logic                issue, issue_last, meta_pop;

    assign head          = meta_mem[mrd_q[MAW-1:0]];
    assign meta_nonempty = mwr_q != mrd_q;
    assign head_lines    = (int'(head.len) + BPL - 1) / BPL;
    assign rd_meta_valid = (state_q == IDLE) && meta_nonempty;
    assign rd_meta       = rd_meta_valid ? head.meta : '0;
    assign rd_len        = rd_meta_valid ? head.len : '0;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        last_bytes_d = last_bytes_q;
        rd_ptr_d     = rd_ptr_q;
        issue        = 1'b0;
        issue_last   = 1'b0;
        meta_pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_meta_valid && rd_fwd_en) begin
                    // First line is read in the accept cycle; the descriptor
                    // is released now so the next frame shows once we are IDLE.
                    issue        = 1'b1;
                    meta_pop     = 1'b1;
                    rd_ptr_d     = rd_ptr_q + PW'(1);
                    last_bytes_d = BW'(int'(head.len) - (head_lines - 1) * BPL);
                    if (head_lines == 1) begin
                        issue_last = 1'b1;
                    end else begin
                        state_d = STREAM;
                        rem_d   = LEN_BITS'(head_lines - 1);
                    end
                end else if (rd_meta_valid && rd_pop) begin
                    meta_pop = 1'b1;
                    rd_ptr_d = rd_ptr_q + PW'(head_lines);
                end
            end
            STREAM: begin
                issue    = 1'b1;
                rd_ptr_d = rd_ptr_q + PW'(1);
                rem_d    = rem_q - LEN_BITS'(1);
                if (rem_q == LEN_BITS'(1)) begin
                    issue_last = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the storage arrays and the RAM read register carry no reset; the
    // pointers alone define what is valid, and output gating hides stale data.
    always_ff @(posedge clk) begin
        if (ram_we)    mem[spec_base[AW-1:0]]    <= wr_data;
        if (meta_push) meta_mem[mwr_q[MAW-1:0]] <= '{len: len_d, meta: wr_meta};
        if (issue)     ram_q                    <= mem[rd_ptr_q[AW-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_spec_q       <= '0;
            wr_cptr_q       <= '0;
            len_q           <= '0;
            ovf_q           <= 1'b0;
            jumbo_q         <= 1'b0;
            mwr_q           <= '0;
            rd_ptr_q        <= '0;
            mrd_q           <= '0;
            state_q         <= IDLE;
            rem_q           <= '0;
            last_bytes_q    <= '0;
            stat_queued     <= 1'b0;
            stat_drop_fifo  <= 1'b0;
            stat_drop_runt  <= 1'b0;
            stat_drop_jumbo <= 1'b0;
            rd_valid        <= 1'b0;
            rd_last         <= 1'b0;
            rd_bytes        <= '0;
        end else begin
            wr_spec_q       <= spec_d;
            wr_cptr_q       <= meta_push ? spec_d : wr_cptr_q;
            len_q           <= len_d;
            ovf_q           <= ovf_d;
            jumbo_q         <= jumbo_d;
            mwr_q           <= mwr_q + MPW'(meta_push);
            rd_ptr_q        <= rd_ptr_d;
            mrd_q           <= mrd_q + MPW'(meta_pop);
            state_q         <= state_d;
            rem_q           <= rem_d;
            last_bytes_q    <= last_bytes_d;
            stat_queued     <= queued_d;
            stat_drop_fifo  <= drop_fifo_d;
            stat_drop_runt  <= drop_runt_d;
            stat_drop_jumbo <= drop_jumbo_d;
            rd_valid        <= issue;
            rd_last         <= issue_last;
            rd_bytes        <= issue ? (issue_last ? last_bytes_d : BW'(BPL)) : '0;
        end
    end

    assign rd_data    = rd_valid ? ram_q : '0;
    assign free_lines = PW'(DEPTH) - (wr_spec_q - rd_ptr_q);

endmodule

// File: doc/rx_packet_fifo.md
Name: rx_packet_fifo

Overview:
- Single-clock, store-and-forward, per-port packet FIFO with commit/rollback.
- Replaces fixed-width gigabit RX buffering with a block parametrised in line width, data depth, metadata depth and frame-size limits.
- Sits between a port's L2 RX pipeline, already crossed into the fabric clock domain, and the switch fabric arbiter.
- Adds behaviour the previous generation lacked:
  - speculative write with rollback on bad/overflowing frames;
  - runt/jumbo policing;
  - discard-without-read (pop) path.

Parameters:
DATA_WIDTH, 128, bits per FIFO line; multiple of 8; BPL = DATA_WIDTH/8 bytes per line
DEPTH, 8192, data FIFO lines; power of 2
META_DEPTH, 2048, packet metadata entries; power of 2
META_WIDTH, 112, user metadata bits stored per frame (header fields)
MIN_FRAME_BYTES, 64, frames shorter are dropped as runts
MAX_FRAME_BYTES, 1522, frames longer are dropped as jumbos
LEN_BITS, $clog2(MAX_FRAME_BYTES+2), frame length width

Ports:
clk  in  1  sole clock; everything below is in this domain
rst_n  in  1  asynchronous active-low reset
wr_start  in  1  first cycle of a new frame (may coincide with wr_valid)
wr_valid  in  1  wr_data beat valid
wr_data  in  DATA_WIDTH  frame data, byte 0 in MSBs
wr_bytes  in  $clog2(BPL+1)  valid bytes in beat (1..BPL; <BPL only on last beat)
wr_meta  in  META_WIDTH  header metadata, sampled on wr_commit
wr_commit  in  1  frame ended good; request enqueue
wr_drop  in  1  frame ended bad (FCS etc.); discard silently
stat_queued  out  1  one-cycle pulse: frame enqueued
stat_drop_fifo  out  1  one-cycle pulse: dropped, insufficient data or metadata space
stat_drop_runt  out  1  one-cycle pulse: dropped, len < MIN_FRAME_BYTES
stat_drop_jumbo  out  1  one-cycle pulse: dropped, len > MAX_FRAME_BYTES
rd_meta_valid  out  1  head frame available
rd_meta  out  META_WIDTH  head frame metadata
rd_len  out  LEN_BITS  head frame length in bytes
rd_fwd_en  in  1  start streaming head frame
rd_pop  in  1  discard head frame without streaming
rd_valid  out  1  output beat valid
rd_data  out  DATA_WIDTH  output beat
rd_bytes  out  $clog2(BPL+1)  valid bytes in output beat
rd_last  out  1  final beat of frame
free_lines  out  $clog2(DEPTH)+1  DEPTH minus lines used by committed and in-progress data

Behaviour:
- Reset: all pointers 0; overflow flag 0; read FSM IDLE; every output 0 except free_lines=DEPTH. Reset mid-frame or mid-stream abandons everything; no stat pulse.
- Pointers are $clog2(DEPTH)+1 bits: wr_spec, wr_commit_ptr, rd_ptr. Used = wr_spec - rd_ptr (modulo wrap). Same scheme in the metadata FIFO.
- Write side:
  - wr_start sets wr_spec := wr_commit_ptr, len := 0, ovf := 0, jumbo := 0. A previous uncommitted frame is discarded with no pulse.
  - On each wr_valid beat:
    - If ovf or jumbo is set, the beat is ignored.
    - Else if used == DEPTH, set ovf.
    - Else if len + wr_bytes > MAX_FRAME_BYTES, set jumbo.
    - Else write RAM[wr_spec], wr_spec++, len += wr_bytes.
- On wr_commit, priority order is:
  - ovf, or metadata FIFO full -> stat_drop_fifo;
  - jumbo -> stat_drop_jumbo;
  - len < MIN_FRAME_BYTES -> stat_drop_runt;
  - otherwise push {len, wr_meta}, wr_commit_ptr := wr_spec, stat_queued.
- On any drop, wr_spec := wr_commit_ptr.
- wr_drop: rollback only, no pulse.
- wr_commit and wr_drop together: wr_drop wins.
- Pulses appear the cycle after commit.
- Commit-to-rd_meta_valid latency is 1 cycle.
- Read FSM IDLE:
  - rd_meta_valid mirrors metadata FIFO non-empty.
  - rd_fwd_en with rd_meta_valid -> STREAM; load remaining = ceil(rd_len/BPL).
  - rd_pop with rd_meta_valid: rd_ptr += ceil(rd_len/BPL); pop meta; stay IDLE.
  - Both asserted: rd_fwd_en wins.
  - Either asserted while !rd_meta_valid: ignored.
- Read FSM STREAM:
  - Issues one RAM read per cycle. RAM latency is 1, so the first rd_valid comes 1 cycle after rd_fwd_en.
  - Beats are contiguous. rd_bytes = BPL except the last beat = rd_len - (lines-1)*BPL.
  - The last beat asserts rd_last. Meta is popped and rd_ptr advanced line-by-line; return to IDLE after the last read issue.
  - rd_meta_valid = 0 during STREAM.
  - rd_fwd_en/rd_pop are ignored in STREAM.
  - A back-to-back rd_fwd_en in the cycle after return to IDLE is legal.
- Concurrency:
  - Write and read run concurrently.
  - Space released by reads in cycle N is usable by writes in cycle N+1.
  - Full check uses the registered rd_ptr.
- Wrap: pointer MSB distinguishes full from empty. Frames may straddle the RAM end.

Test Plan:
- 64-byte frame (4 beats × 16B), commit -> stat_queued; rd_len=64. fwd_en -> 4 beats starting 1 cycle later; rd_last on beat 4; rd_bytes=16 each.
- 65-byte frame -> 5 beats, final rd_bytes=1. 60-byte frame -> stat_drop_runt, free_lines unchanged. 1523-byte frame -> stat_drop_jumbo; free_lines restored after commit.
- DEPTH=16, fill 3 committed 64B frames (12 lines), 5-line frame -> ovf, stat_drop_fifo. Then a 4-line frame -> queued (free_lines 0).
- wr_start mid-frame then 64B commit -> only second frame queued, no drop pulse. wr_drop plus wr_commit same cycle -> nothing queued.
- Queue 3 frames; rd_pop first -> free_lines rises by 4, meta shows frame 2; rd_fwd_en+rd_pop together streams frame 2.
- Assert rst_n low mid-STREAM -> all outputs 0 immediately, free_lines=DEPTH, rd_meta_valid=0 after release.
